// File: rtl/corr_peak_detect_if.sv
// Register bus, correlator stream and peak report bundle for corr_peak_detect.
interface corr_peak_detect_if #(
  parameter int IDX_W = 16
);
  logic        [31:0]      din;
  logic        [31:0]      dout;
  logic        [3:0]       addr;
  logic                    strobe;
  logic                    sync;
  logic                    push_corr;
  logic signed [31:0]      corr;
  logic                    push_peak;
  logic        [31:0]      peak_mag;
  logic        [IDX_W-1:0] peak_idx;
  logic                    lock;

  // Host / correlator side drives the bus and the correlation stream.
  modport master (
    output din, addr, strobe, sync, push_corr, corr,
    input  dout, push_peak, peak_mag, peak_idx, lock
  );

  // Peak detector side.
  modport slave (
    input  din, addr, strobe, sync, push_corr, corr,
    output dout, push_peak, peak_mag, peak_idx, lock
  );
endinterface

// File: rtl/corr_peak_detect.sv
// Windowed peak search over correlator output: largest |corr|, its index
// within the window, and a threshold lock decision, with a small register bus.
module corr_peak_detect #(
  parameter int          IDX_W      = 16,
  parameter int unsigned DEF_WINDOW = 16,
  parameter int unsigned DEF_THRESH = 0
) (
  input  logic              clk,
  input  logic              reset,
  corr_peak_detect_if.slave bus
);

  typedef enum logic {IDLE, SEARCH} state_e;

  localparam logic [31:0] MAG_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] CORR_MIN = 32'h8000_0000;

  state_e           state_q, state_d;

  logic [IDX_W-1:0] window_q;
  logic [31:0]      thresh_q;
  logic [IDX_W-1:0] act_win_q;

  logic             v_q;
  logic [31:0]      mag_q;

  logic [31:0]      max_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] cnt_q;

  logic             push_peak_q;
  logic [31:0]      peak_mag_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic             lock_q;
  logic [31:0]      dout_q;

  logic             wr_window, wr_thresh;
  logic [IDX_W-1:0] window_nxt;
  logic [IDX_W-1:0] window_eff;
  logic [31:0]      mag_in;
  logic             s2_fire, report;
  logic [31:0]      cand_max;
  logic [IDX_W-1:0] cand_idx;

  assign wr_window  = bus.strobe && (bus.addr == 4'd0);
  assign wr_thresh  = bus.strobe && (bus.addr == 4'd4);
  // A write landing on the same edge as a shadow copy becomes the next window.
  assign window_nxt = wr_window ? bus.din[IDX_W-1:0] : window_q;
  assign window_eff = (window_nxt == '0) ? IDX_W'(1) : window_nxt;

  // |corr|, with the single unrepresentable value clipped to the largest positive.
  assign mag_in = (bus.corr == CORR_MIN) ? MAG_SAT :
                  bus.corr[31] ? 32'(-bus.corr) : 32'(bus.corr);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: sync starts (or restarts) the search from any state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    if (bus.sync) state_d = SEARCH;
  end

  // Output decode: which S2 edges count, and which of those close the window.
  always_comb begin
    s2_fire = (state_q == SEARCH) && v_q && !bus.sync;
    report  = s2_fire && (cnt_q == act_win_q - IDX_W'(1));
  end

  // Running-max candidate; strict compare keeps the earliest index on ties.
  always_comb begin
    cand_max = max_q;
    cand_idx = max_idx_q;
    if (mag_q > max_q) begin
      cand_max = mag_q;
      cand_idx = cnt_q;
    end
  end

  // Programmable window and threshold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= IDX_W'(DEF_WINDOW);
      thresh_q <= DEF_THRESH;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (wr_window) window_q <= bus.din[IDX_W-1:0];
      if (wr_thresh) thresh_q <= bus.din;
    end
  end

  // Stage S1: register magnitude of each incoming sample; sync drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= 1'b0;
      mag_q <= '0;
    end else begin
      v_q <= bus.push_corr && !bus.sync;
      if (bus.push_corr) mag_q <= mag_in;
    end
  end

  // Stage S2: running max, sample counter and the active-window shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      act_win_q <= (IDX_W'(DEF_WINDOW) == '0) ? IDX_W'(1) : IDX_W'(DEF_WINDOW);
    end else if (bus.sync) begin
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      act_win_q <= window_eff;
    end else if (report) begin
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      act_win_q <= window_eff;
    end else if (s2_fire) begin
      max_q     <= cand_max;
      max_idx_q <= cand_idx;
      cnt_q     <= cnt_q + IDX_W'(1);
    end
  end

  // Report outputs: one-cycle pulse, result fields held until the next report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_peak_q <= 1'b0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      lock_q      <= 1'b0;
    end else begin
      push_peak_q <= report;
      if (report) begin
        peak_mag_q <= cand_max;
        peak_idx_q <= cand_idx;
        lock_q     <= (cand_max >= thresh_q);
      end
    end
  end

  // Registered read mux; unmapped addresses leave dout unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      case (bus.addr)
        4'd0:    dout_q <= {{(32-IDX_W){1'b0}}, window_q};
        4'd4:    dout_q <= thresh_q;
        4'd8:    dout_q <= peak_mag_q;
        4'd12:   dout_q <= {lock_q, {(31-IDX_W){1'b0}}, peak_idx_q};
        default: dout_q <= dout_q;
      endcase
    end
  end

  assign bus.dout      = dout_q;
  assign bus.push_peak = push_peak_q;
  assign bus.peak_mag  = peak_mag_q;
  assign bus.peak_idx  = peak_idx_q;
  assign bus.lock      = lock_q;

endmodule

// File: tb/tb_corr_peak_detect.sv
// Self-checking bench for corr_peak_detect: directed scenarios plus randomized
// windows checked against a per-window max model.
module tb_corr_peak_detect;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corr_peak_detect_if #(.IDX_W(16)) bus ();

  corr_peak_detect #(.IDX_W(16), .DEF_WINDOW(16), .DEF_THRESH(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] mag;
    logic [15:0] idx;
    logic        lk;
    int          c;
  } rep_t;
  rep_t reps[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every report pulse together with the edge count it followed.
  always @(negedge clk) begin
    if (bus.push_peak === 1'b1)
      reps.push_back('{mag: bus.peak_mag, idx: bus.peak_idx, lk: bus.lock, c: cyc});
  end

  task automatic step(input bit p, input logic [31:0] c, input bit s,
                      input bit st, input logic [3:0] a, input logic [31:0] d);
    bus.push_corr = p;
    bus.corr      = c;
    bus.sync      = s;
    bus.strobe    = st;
    bus.addr      = a;
    bus.din       = d;
    @(posedge clk);
    #1;
    bus.push_corr = 1'b0;
    bus.sync      = 1'b0;
    bus.strobe    = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    step(1'b1, v, 1'b0, 1'b0, 4'd1, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b0, 32'd0, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_sync();
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 4'd1, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    step(1'b0, 32'd0, 1'b0, 1'b0, a, 32'd0);
    v = bus.dout;
  endtask

  // Reference magnitude: |v| as a signed 32-bit number, clipped to 2^31-1.
  function automatic logic [31:0] ref_mag(input logic [31:0] v);
    longint s;
    s = longint'(signed'(v));
    if (s < 0) s = -s;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    return 32'(s);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    bus.push_corr = 1'b0; bus.corr = '0; bus.sync = 1'b0;
    bus.strobe = 1'b0; bus.addr = 4'd0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.push_peak !== 1'b0) begin bad++; $display("FAIL rst_push_peak got=%b want=0", bus.push_peak); end
    total++; if (bus.peak_mag !== 32'd0) begin bad++; $display("FAIL rst_peak_mag got=%h want=0", bus.peak_mag); end
    total++; if (bus.peak_idx !== 16'd0) begin bad++; $display("FAIL rst_peak_idx got=%h want=0", bus.peak_idx); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL rst_lock got=%b want=0", bus.lock); end
    total++; if (bus.dout !== 32'd0) begin bad++; $display("FAIL rst_dout got=%h want=0", bus.dout); end
    reset = 1'b0;
    rd(4'd0, v);
    total++; if (v !== 32'd16) begin bad++; $display("FAIL rst_window_read got=%h want=10", v); end
    rd(4'd4, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_thresh_read got=%h want=0", v); end
  endtask

  task automatic test_basic_peak();
    logic [31:0] v;
    int lp;
    wr(4'd0, 32'd4);
    wr(4'd4, 32'd1000);
    do_sync();
    reps.delete();
    push(32'd10);
    push(-32'sd3000);
    push(32'd2500);
    push(32'd3000);
    lp = cyc;
    idle(4);
    total++; if (reps.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", reps.size()); end
    if (reps.size() >= 1) begin
      total++; if (reps[0].mag !== 32'd3000) begin bad++; $display("FAIL basic_mag got=%0d want=3000", reps[0].mag); end
      total++; if (reps[0].idx !== 16'd1) begin bad++; $display("FAIL basic_idx got=%0d want=1", reps[0].idx); end
      total++; if (reps[0].lk !== 1'b1) begin bad++; $display("FAIL basic_lock got=%b want=1", reps[0].lk); end
      total++; if (reps[0].c !== lp + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", reps[0].c, lp + 1); end
    end
    rd(4'd8, v);
    total++; if (v !== 32'd3000) begin bad++; $display("FAIL basic_read_mag got=%0d want=3000", v); end
    rd(4'd12, v);
    total++; if (v !== 32'h8000_0001) begin bad++; $display("FAIL basic_read_status got=%h want=80000001", v); end
  endtask

  task automatic test_saturation();
    wr(4'd4, 32'd0);
    wr(4'd0, 32'd2);
    do_sync();
    reps.delete();
    push(32'h8000_0000);
    push(32'd5);
    push(32'd7);
    push(32'd9);
    idle(4);
    total++; if (reps.size() !== 2) begin bad++; $display("FAIL sat_count got=%0d want=2", reps.size()); end
    if (reps.size() >= 2) begin
      total++; if (reps[0].mag !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_mag got=%h want=7fffffff", reps[0].mag); end
      total++; if (reps[0].idx !== 16'd0) begin bad++; $display("FAIL sat_idx got=%0d want=0", reps[0].idx); end
      total++; if (reps[1].mag !== 32'd9) begin bad++; $display("FAIL cont_mag got=%0d want=9", reps[1].mag); end
      total++; if (reps[1].idx !== 16'd1) begin bad++; $display("FAIL cont_idx got=%0d want=1", reps[1].idx); end
      total++; if (reps[1].lk !== 1'b1) begin bad++; $display("FAIL cont_lock got=%b want=1", reps[1].lk); end
      total++; if (reps[1].c - reps[0].c !== 2) begin bad++; $display("FAIL cont_spacing got=%0d want=2", reps[1].c - reps[0].c); end
    end
  endtask

  task automatic test_restart_collision();
    wr(4'd0, 32'd4);
    do_sync();
    reps.delete();
    push(32'd500);
    push(32'd600);
    step(1'b1, 32'd9999, 1'b1, 1'b0, 4'd1, 32'd0);
    push(32'd5);
    push(32'd6);
    push(32'd7);
    push(32'd8);
    idle(4);
    total++; if (reps.size() !== 1) begin bad++; $display("FAIL restart_count got=%0d want=1", reps.size()); end
    if (reps.size() >= 1) begin
      total++; if (reps[0].mag !== 32'd8) begin bad++; $display("FAIL restart_mag got=%0d want=8", reps[0].mag); end
      total++; if (reps[0].idx !== 16'd3) begin bad++; $display("FAIL restart_idx got=%0d want=3", reps[0].idx); end
    end
  endtask

  task automatic test_thresh_midwrite();
    logic [31:0] v;
    wr(4'd4, 32'd100);
    wr(4'd0, 32'd3);
    do_sync();
    reps.delete();
    push(32'd50);
    push(-32'sd60);
    step(1'b1, 32'd40, 1'b0, 1'b1, 4'd0, 32'd1);
    push(32'd200);
    push(32'd300);
    idle(4);
    total++; if (reps.size() !== 3) begin bad++; $display("FAIL thr_count got=%0d want=3", reps.size()); end
    if (reps.size() >= 3) begin
      total++; if (reps[0].mag !== 32'd60) begin bad++; $display("FAIL thr_mag got=%0d want=60", reps[0].mag); end
      total++; if (reps[0].idx !== 16'd1) begin bad++; $display("FAIL thr_idx got=%0d want=1", reps[0].idx); end
      total++; if (reps[0].lk !== 1'b0) begin bad++; $display("FAIL thr_lock got=%b want=0", reps[0].lk); end
      total++; if (reps[1].mag !== 32'd200 || reps[1].idx !== 16'd0 || reps[1].lk !== 1'b1)
        begin bad++; $display("FAIL win1_a got=%0d/%0d/%b want=200/0/1", reps[1].mag, reps[1].idx, reps[1].lk); end
      total++; if (reps[2].mag !== 32'd300 || reps[2].idx !== 16'd0 || reps[2].lk !== 1'b1)
        begin bad++; $display("FAIL win1_b got=%0d/%0d/%b want=300/0/1", reps[2].mag, reps[2].idx, reps[2].lk); end
    end
    rd(4'd0, v);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL thr_window_read got=%0d want=1", v); end
  endtask

  task automatic test_reset_idle();
    logic [31:0] v;
    wr(4'd0, 32'd4);
    do_sync();
    push(32'd1);
    push(32'd2);
    #2 reset = 1'b1;
    #1;
    total++; if (bus.peak_mag !== 32'd0 || bus.lock !== 1'b0 || bus.push_peak !== 1'b0)
      begin bad++; $display("FAIL async_reset got=%h/%b/%b want=0/0/0", bus.peak_mag, bus.lock, bus.push_peak); end
    @(posedge clk);
    #1 reset = 1'b0;
    reps.delete();
    for (int i = 0; i < 20; i++) push(32'd1000);
    idle(4);
    total++; if (reps.size() !== 0) begin bad++; $display("FAIL idle_count got=%0d want=0", reps.size()); end
    total++; if (bus.peak_mag !== 32'd0 || bus.peak_idx !== 16'd0)
      begin bad++; $display("FAIL idle_outputs got=%h/%h want=0/0", bus.peak_mag, bus.peak_idx); end
    rd(4'd0, v);
    total++; if (v !== 32'd16) begin bad++; $display("FAIL idle_window_read got=%0d want=16", v); end
  endtask

  // Random windows; gaps=0 makes it a back-to-back (push every cycle) run.
  task automatic test_random(input int rounds, input bit gaps);
    for (int r = 0; r < rounds; r++) begin
      int w, eff, nwin, k;
      logic [31:0] th;
      logic [31:0] samp[$];
      w   = $urandom_range(0, 6);
      eff = (w == 0) ? 1 : w;
      th  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 5));
      wr(4'd0, 32'(w));
      wr(4'd4, th);
      do_sync();
      reps.delete();
      nwin = $urandom_range(1, 4);
      for (int i = 0; i < nwin * eff; i++) begin
        int mode;
        logic [31:0] v;
        if (gaps && $urandom_range(0, 2) == 0) idle(1);
        mode = $urandom_range(0, 7);
        if (mode == 0)      v = 32'h8000_0000;
        else if (mode <= 3) v = 32'($signed($urandom_range(0, 8)) - 4);
        else                v = $urandom;
        push(v);
        samp.push_back(v);
      end
      idle(4);
      total++; if (reps.size() !== nwin) begin bad++; $display("FAIL rnd_count r=%0d got=%0d want=%0d", r, reps.size(), nwin); end
      k = 0;
      for (int wi = 0; wi < nwin && wi < reps.size(); wi++) begin
        logic [31:0] best;
        int bi;
        best = 0;
        bi = 0;
        for (int j = 0; j < eff; j++) begin
          if (ref_mag(samp[k + j]) > best) begin
            best = ref_mag(samp[k + j]);
            bi = j;
          end
        end
        k += eff;
        total++;
        if (reps[wi].mag !== best || reps[wi].idx !== 16'(bi) || reps[wi].lk !== (best >= th)) begin
          bad++;
          $display("FAIL rnd_report r=%0d w=%0d got=%h/%0d/%b want=%h/%0d/%b",
                   r, wi, reps[wi].mag, reps[wi].idx, reps[wi].lk, best, bi, best >= th);
        end
        if (!gaps && wi > 0) begin
          total++;
          if (reps[wi].c - reps[wi-1].c !== eff) begin
            bad++;
            $display("FAIL b2b_spacing r=%0d got=%0d want=%0d", r, reps[wi].c - reps[wi-1].c, eff);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_peak();
    test_saturation();
    test_restart_collision();
    test_thresh_midwrite();
    test_reset_idle();
    test_random(12, 1'b1);
    test_random(8, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
